fft_stage_ctrl: RTL and testbench



---
 rtl/fft_stage_ctrl_if.sv | 36 +++
 rtl/fft_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_fft_stage_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_ctrl_if.sv
// Handshake and operand bus between the stage input stream, the frame scheduler
// and the butterfly datapath. "master" is the scheduler side, "slave" the environment.
interface fft_stage_ctrl_if #(
    parameter int WIDTH    = 12,
    parameter int NUM_PAIR = 8
);
    localparam int IDX_W = $clog2(NUM_PAIR);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] din_re;
    logic signed [WIDTH-1:0] din_im;

    logic                    bfly_valid;
    logic                    bfly_ready;
    logic                    bfly_op;
    logic [IDX_W-1:0]        bfly_idx;
    logic signed [WIDTH-1:0] bfly_a_re;
    logic signed [WIDTH-1:0] bfly_a_im;
    logic signed [WIDTH-1:0] bfly_b_re;
    logic signed [WIDTH-1:0] bfly_b_im;

    logic                    frame_done;

    modport master (
        input  in_valid, din_re, din_im, bfly_ready,
        output in_ready, bfly_valid, bfly_op, bfly_idx,
               bfly_a_re, bfly_a_im, bfly_b_re, bfly_b_im, frame_done
    );

    modport slave (
        output in_valid, din_re, din_im, bfly_ready,
        input  in_ready, bfly_valid, bfly_op, bfly_idx,
               bfly_a_re, bfly_a_im, bfly_b_re, bfly_b_im, frame_done
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Radix-2 stage frame scheduler: buffers 2*NUM_PAIR samples, then presents
// (x[k], x[k+NUM_PAIR]) pairs to the butterfly, first as SUM then as DIFF.
module fft_stage_ctrl #(
    parameter int WIDTH    = 12,
    parameter int NUM_PAIR = 8
) (
    input logic              clk,
    input logic              rstn,
    fft_stage_ctrl_if.master bus
);
    localparam int FRAME = 2 * NUM_PAIR;
    localparam int WW    = $clog2(FRAME);
    localparam int KW    = $clog2(NUM_PAIR);

    typedef enum logic [1:0] {LOAD, ISSUE_SUM, ISSUE_DIFF, DONE} state_t;

    state_t             state_q, state_d;
    logic [WW-1:0]      wr_cnt_q, wr_cnt_d;
    logic [KW-1:0]      k_q, k_d;
    logic [2*WIDTH-1:0] mem_q [FRAME];

    logic               in_ready_q, in_ready_d;
    logic               bfly_valid_q, bfly_valid_d;
    logic               bfly_op_q, bfly_op_d;
    logic [KW-1:0]      bfly_idx_q, bfly_idx_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] b_q, b_d;
    logic               frame_done_q, frame_done_d;

    logic               accept;
    logic               xfer;
    logic               issuing;

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = bfly_valid_q && bus.bfly_ready;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        k_d      = k_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (wr_cnt_q == WW'(FRAME - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = ISSUE_SUM;
                    end else begin
                        wr_cnt_d = wr_cnt_q + WW'(1);
                    end
                end
            end
            ISSUE_SUM: begin
                if (xfer) begin
                    if (k_q == KW'(NUM_PAIR - 1)) begin
                        k_d     = '0;
                        state_d = ISSUE_DIFF;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ISSUE_DIFF: begin
                if (xfer) begin
                    if (k_q == KW'(NUM_PAIR - 1)) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DONE: begin
                state_d = LOAD;
                if (accept) begin
                    wr_cnt_d = wr_cnt_q + WW'(1);
                end
            end
            default: state_d = LOAD;
        endcase

        // Outputs are derived from the next state so they register on the same
        // edge as the transition; during a stall state, k and mem are frozen.
        issuing      = (state_d == ISSUE_SUM) || (state_d == ISSUE_DIFF);
        bfly_valid_d = issuing;
        bfly_op_d    = (state_d == ISSUE_DIFF);
        bfly_idx_d   = issuing ? k_d : '0;
        a_d          = issuing ? mem_q[{1'b0, k_d}] : '0;
        b_d          = issuing ? mem_q[{1'b1, k_d}] : '0;
        frame_done_d = (state_d == DONE);
        in_ready_d   = (state_d == LOAD) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= LOAD;
            wr_cnt_q     <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b1;
            bfly_valid_q <= 1'b0;
            bfly_op_q    <= 1'b0;
            bfly_idx_q   <= '0;
            a_q          <= '0;
            b_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            k_q          <= k_d;
            in_ready_q   <= in_ready_d;
            bfly_valid_q <= bfly_valid_d;
            bfly_op_q    <= bfly_op_d;
            bfly_idx_q   <= bfly_idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Sample buffer keeps its contents across reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_cnt_q] <= {bus.din_re, bus.din_im};
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.bfly_valid = bfly_valid_q;
    assign bus.bfly_op    = bfly_op_q;
    assign bus.bfly_idx   = bfly_idx_q;
    assign bus.bfly_a_re  = a_q[2*WIDTH-1:WIDTH];
    assign bus.bfly_a_im  = a_q[WIDTH-1:0];
    assign bus.bfly_b_re  = b_q[2*WIDTH-1:WIDTH];
    assign bus.bfly_b_im  = b_q[WIDTH-1:0];
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: loads frames, captures every issued pair
// and compares against hand-derived frame contents.
module tb_fft_stage_ctrl;
    localparam int WIDTH    = 12;
    localparam int NUM_PAIR = 8;
    localparam int FRAME    = 2 * NUM_PAIR;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fft_stage_ctrl_if #(.WIDTH(WIDTH), .NUM_PAIR(NUM_PAIR)) bus ();
    fft_stage_ctrl #(.WIDTH(WIDTH), .NUM_PAIR(NUM_PAIR)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    int fr_re [FRAME];
    int fr_im [FRAME];
    logic idle_valid;
    int   idle_re, idle_im;
    int   load_busy, load_done;

    integer cap_op [FRAME], cap_idx [FRAME], cap_are [FRAME], cap_aim [FRAME], cap_bre [FRAME], cap_bim [FRAME];
    integer st_op [4], st_idx [4], st_are [4], st_aim [4], st_bre [4], st_bim [4];
    int cap_n, st_n, valid_cycles, first_valid, done_cyc, ready_hi, saw99, timeout;
    logic done_valid;

    // Presents samples first..FRAME-1 on consecutive cycles; leaves the last one driven.
    task automatic load_frame(input int first);
        for (int n = first; n < FRAME; n++) begin
            @(negedge clk);
            if (bus.frame_done) load_done++;
            if (!bus.in_ready) load_busy++;
            bus.in_valid = 1'b1;
            bus.din_re   = WIDTH'(fr_re[n]);
            bus.din_im   = WIDTH'(fr_im[n]);
        end
    endtask

    // Records each transferred pair (and stalled presentations) until frame_done.
    task automatic capture_issue(input int stall_idx, input int stall_len);
        cap_n = 0; st_n = 0; valid_cycles = 0; first_valid = -1; done_cyc = -1;
        ready_hi = 0; saw99 = 0; timeout = 1; done_valid = 1'bx;
        for (int j = 0; j < FRAME; j++) begin
            cap_op[j] = -9999; cap_idx[j] = -9999; cap_are[j] = -9999;
            cap_aim[j] = -9999; cap_bre[j] = -9999; cap_bim[j] = -9999;
        end
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.in_valid = idle_valid;
                bus.din_re   = WIDTH'(idle_re);
                bus.din_im   = WIDTH'(idle_im);
            end
            if (bus.frame_done) begin
                done_cyc = cyc; done_valid = bus.bfly_valid; timeout = 0;
                bus.bfly_ready = 1'b1;
                break;
            end
            if (bus.bfly_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
                if (bus.in_ready) ready_hi++;
                if (bus.bfly_a_re == 99 || bus.bfly_a_im == 99 || bus.bfly_b_re == 99 || bus.bfly_b_im == 99) saw99++;
                if (!bus.bfly_op && int'(bus.bfly_idx) == stall_idx && st_n < stall_len) begin
                    bus.bfly_ready = 1'b0;
                    st_op[st_n] = bus.bfly_op;        st_idx[st_n] = bus.bfly_idx;
                    st_are[st_n] = bus.bfly_a_re;     st_aim[st_n] = bus.bfly_a_im;
                    st_bre[st_n] = bus.bfly_b_re;     st_bim[st_n] = bus.bfly_b_im;
                    st_n++;
                end else begin
                    bus.bfly_ready = 1'b1;
                    if (cap_n < FRAME) begin
                        cap_op[cap_n] = bus.bfly_op;    cap_idx[cap_n] = bus.bfly_idx;
                        cap_are[cap_n] = bus.bfly_a_re; cap_aim[cap_n] = bus.bfly_a_im;
                        cap_bre[cap_n] = bus.bfly_b_re; cap_bim[cap_n] = bus.bfly_b_im;
                    end
                    cap_n++;
                end
            end else begin
                bus.bfly_ready = (cyc % 2 == 0);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.bfly_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got ready=%b valid=%b done=%b want 1 0 0", bus.in_ready, bus.bfly_valid, bus.frame_done);
        end
        checks++;
        if ({bus.bfly_op, bus.bfly_idx, bus.bfly_a_re, bus.bfly_a_im, bus.bfly_b_re, bus.bfly_b_im} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_operands got op=%b idx=%0d a=(%0d,%0d) b=(%0d,%0d) want all 0", bus.bfly_op, bus.bfly_idx,
                     bus.bfly_a_re, bus.bfly_a_im, bus.bfly_b_re, bus.bfly_b_im);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic_frame;
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = n; fr_im[n] = -n; end
        idle_valid = 1'b0; idle_re = 0; idle_im = 0; load_busy = 0;
        load_frame(0);
        capture_issue(-1, 0);
        checks++;
        if (timeout !== 0 || done_cyc !== 17 || done_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_done got cyc=%0d valid=%b timeout=%0d want cyc=17 valid=0", done_cyc, done_valid, timeout);
        end
        checks++;
        if (first_valid !== 1 || valid_cycles !== 16 || load_busy !== 0) begin
            failures++;
            $display("[TB] FAIL basic_timing got first=%0d valid_cycles=%0d busy=%0d want 1 16 0", first_valid, valid_cycles, load_busy);
        end
        checks++;
        if (cap_are[5] !== 5 || cap_aim[5] !== -5 || cap_bre[5] !== 13 || cap_bim[5] !== -13 || cap_op[13] !== 1 || cap_idx[13] !== 5) begin
            failures++;
            $display("[TB] FAIL basic_pair5 got a=(%0d,%0d) b=(%0d,%0d) op13=%0d idx13=%0d want (5,-5) (13,-13) 1 5",
                     cap_are[5], cap_aim[5], cap_bre[5], cap_bim[5], cap_op[13], cap_idx[13]);
        end
        for (int j = 0; j < FRAME; j++) begin
            int k = j % NUM_PAIR;
            checks++;
            if (cap_op[j] !== j / NUM_PAIR || cap_idx[j] !== k || cap_are[j] !== k || cap_aim[j] !== -k ||
                cap_bre[j] !== k + 8 || cap_bim[j] !== -k - 8) begin
                failures++;
                $display("[TB] FAIL basic_seq j=%0d got op=%0d idx=%0d a=(%0d,%0d) b=(%0d,%0d) want op=%0d idx=%0d a=(%0d,%0d) b=(%0d,%0d)",
                         j, cap_op[j], cap_idx[j], cap_are[j], cap_aim[j], cap_bre[j], cap_bim[j], j / NUM_PAIR, k, k, -k, k + 8, -k - 8);
            end
        end
    endtask

    task automatic test_backpressure;
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = n; fr_im[n] = -n; end
        idle_valid = 1'b0;
        load_frame(0);
        capture_issue(5, 3);
        checks++;
        if (timeout !== 0 || valid_cycles !== 19 || done_cyc !== 20 || st_n !== 3) begin
            failures++;
            $display("[TB] FAIL bp_span got valid_cycles=%0d done=%0d stalls=%0d want 19 20 3", valid_cycles, done_cyc, st_n);
        end
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (st_op[s] !== 0 || st_idx[s] !== 5 || st_are[s] !== 5 || st_aim[s] !== -5 || st_bre[s] !== 13 || st_bim[s] !== -13) begin
                failures++;
                $display("[TB] FAIL bp_hold s=%0d got op=%0d idx=%0d a=(%0d,%0d) b=(%0d,%0d) want 0 5 (5,-5) (13,-13)",
                         s, st_op[s], st_idx[s], st_are[s], st_aim[s], st_bre[s], st_bim[s]);
            end
        end
        for (int j = 0; j < FRAME; j++) begin
            int k = j % NUM_PAIR;
            checks++;
            if (cap_op[j] !== j / NUM_PAIR || cap_idx[j] !== k || cap_are[j] !== k || cap_bim[j] !== -k - 8) begin
                failures++;
                $display("[TB] FAIL bp_seq j=%0d got op=%0d idx=%0d a_re=%0d b_im=%0d want %0d %0d %0d %0d",
                         j, cap_op[j], cap_idx[j], cap_are[j], cap_bim[j], j / NUM_PAIR, k, k, -k - 8);
            end
        end
    endtask

    task automatic test_input_ignored;
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = n + 20; fr_im[n] = n + 40; end
        idle_valid = 1'b1; idle_re = 99; idle_im = 99;
        load_frame(0);
        capture_issue(-1, 0);
        checks++;
        if (timeout !== 0 || ready_hi !== 0 || saw99 !== 0 || valid_cycles !== 16) begin
            failures++;
            $display("[TB] FAIL ign_issue got ready_hi=%0d saw99=%0d valid_cycles=%0d want 0 0 16", ready_hi, saw99, valid_cycles);
        end
        checks++;
        if (cap_are[7] !== 27 || cap_aim[7] !== 47 || cap_bre[7] !== 35 || cap_bim[7] !== 55) begin
            failures++;
            $display("[TB] FAIL ign_pair7 got a=(%0d,%0d) b=(%0d,%0d) want (27,47) (35,55)", cap_are[7], cap_aim[7], cap_bre[7], cap_bim[7]);
        end
        // The (99,99) still offered during DONE becomes x[0] of the next frame.
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = 3 * n; fr_im[n] = 7; end
        idle_valid = 1'b0;
        load_frame(1);
        capture_issue(-1, 0);
        checks++;
        if (cap_are[0] !== 99 || cap_aim[0] !== 99 || cap_bre[0] !== 24 || cap_bim[0] !== 7 || cap_are[9] !== 3) begin
            failures++;
            $display("[TB] FAIL ign_next got a=(%0d,%0d) b=(%0d,%0d) a9=%0d want (99,99) (24,7) 3",
                     cap_are[0], cap_aim[0], cap_bre[0], cap_bim[0], cap_are[9]);
        end
    endtask

    task automatic test_extremes;
        for (int n = 0; n < FRAME; n++) begin
            fr_re[n] = (n < NUM_PAIR) ? -2048 : 2047;
            fr_im[n] = (n < NUM_PAIR) ? 2047 : -2048;
        end
        idle_valid = 1'b0;
        bus.bfly_ready = 1'b0;
        load_frame(0);
        capture_issue(-1, 0);
        checks++;
        if (timeout !== 0 || first_valid !== 1 || valid_cycles !== 16) begin
            failures++;
            $display("[TB] FAIL ext_timing got first=%0d valid_cycles=%0d want 1 16", first_valid, valid_cycles);
        end
        for (int j = 0; j < FRAME; j++) begin
            checks++;
            if (cap_are[j] !== -2048 || cap_aim[j] !== 2047 || cap_bre[j] !== 2047 || cap_bim[j] !== -2048) begin
                failures++;
                $display("[TB] FAIL ext_seq j=%0d got a=(%0d,%0d) b=(%0d,%0d) want (-2048,2047) (2047,-2048)",
                         j, cap_are[j], cap_aim[j], cap_bre[j], cap_bim[j]);
            end
        end
    endtask

    task automatic test_reset_mid_load;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.din_re   = WIDTH'(55 + n);
            bus.din_im   = WIDTH'(3);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.bfly_valid !== 1'b0 || bus.frame_done !== 1'b0 ||
            {bus.bfly_op, bus.bfly_idx, bus.bfly_a_re, bus.bfly_b_re} !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outputs got ready=%b valid=%b done=%b op=%b idx=%0d want 1 0 0 0 0",
                     bus.in_ready, bus.bfly_valid, bus.frame_done, bus.bfly_op, bus.bfly_idx);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = 100 + n; fr_im[n] = 0; end
        load_frame(0);
        capture_issue(-1, 0);
        checks++;
        if (timeout !== 0 || first_valid !== 1 || cap_are[0] !== 100 || cap_aim[0] !== 0 || cap_bre[0] !== 108 || cap_bim[0] !== 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_pair0 got first=%0d a=(%0d,%0d) b=(%0d,%0d) want 1 (100,0) (108,0)",
                     first_valid, cap_are[0], cap_aim[0], cap_bre[0], cap_bim[0]);
        end
        for (int j = 0; j < FRAME; j++) begin
            int k = j % NUM_PAIR;
            checks++;
            if (cap_are[j] !== 100 + k || cap_bre[j] !== 108 + k || cap_op[j] !== j / NUM_PAIR) begin
                failures++;
                $display("[TB] FAIL rst_mid_seq j=%0d got a_re=%0d b_re=%0d op=%0d want %0d %0d %0d",
                         j, cap_are[j], cap_bre[j], cap_op[j], 100 + k, 108 + k, j / NUM_PAIR);
            end
        end
    endtask

    task automatic test_back_to_back;
        load_done = 0;
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = 200 + n; fr_im[n] = -1 - n; end
        idle_valid = 1'b1; idle_re = 300; idle_im = -300;
        load_frame(0);
        capture_issue(-1, 0);
        checks++;
        if (timeout !== 0 || done_cyc !== 17 || cap_are[15] !== 207 || cap_bim[15] !== -16 || cap_op[15] !== 1) begin
            failures++;
            $display("[TB] FAIL b2b_frame1 got done=%0d a_re15=%0d b_im15=%0d op15=%0d want 17 207 -16 1",
                     done_cyc, cap_are[15], cap_bim[15], cap_op[15]);
        end
        for (int n = 0; n < FRAME; n++) begin fr_re[n] = 300 + n; fr_im[n] = -300 - n; end
        idle_valid = 1'b0;
        load_frame(1);
        capture_issue(-1, 0);
        checks++;
        if (timeout !== 0 || done_cyc !== 17 || valid_cycles !== 16 || load_done !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_frame2_timing got done=%0d valid_cycles=%0d extra_done=%0d want 17 16 0",
                     done_cyc, valid_cycles, load_done);
        end
        for (int j = 0; j < FRAME; j++) begin
            int k = j % NUM_PAIR;
            checks++;
            if (cap_idx[j] !== k || cap_are[j] !== 300 + k || cap_aim[j] !== -300 - k || cap_bre[j] !== 308 + k || cap_bim[j] !== -308 - k) begin
                failures++;
                $display("[TB] FAIL b2b_seq j=%0d got idx=%0d a=(%0d,%0d) b=(%0d,%0d) want %0d (%0d,%0d) (%0d,%0d)",
                         j, cap_idx[j], cap_are[j], cap_aim[j], cap_bre[j], cap_bim[j], k, 300 + k, -300 - k, 308 + k, -308 - k);
            end
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.din_re     = '0;
        bus.din_im     = '0;
        bus.bfly_ready = 1'b1;
        load_busy      = 0;
        load_done      = 0;
        #12;
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_input_ignored;
        test_extremes;
        test_reset_mid_load;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
